// File: rtl/reg_file_wb_sched.sv
// reg_file_wb_sched
// Writeback scheduler and scoreboard for a single-write-port register file.
// Two requesters compete for the write port: ALU writeback and memory-load
// writeback. Round-robin fairness decides conflicts. All register file write
// signals come straight from flops. A pending-write bit per register lets
// decode stall on read-after-write hazards.
//
// Ports
//   CLK, RST_n                     clock, async active-low reset
//   alu_valid/waddr/data, ready    ALU writeback request and handshake
//   mem_valid/waddr/data, ready    load writeback request and handshake
//   iss_valid, iss_waddr           issuing instruction destination (sets pending)
//   raddrA, raddrB, hazA, hazB     source registers and their hazard flags
//   write_en, waddr, dataALU_in,
//   dataMem_in, data_source        registered register file write port
//
// Arbiter state
//   last_grant | meaning
//   0          | ALU won the most recent handshake, MEM wins next conflict
//   1          | MEM won the most recent handshake, ALU wins next conflict
module reg_file_wb_sched #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_waddr,
  input  logic [W-1:0] alu_data,
  output logic         alu_ready,
  input  logic         mem_valid,
  input  logic [D-1:0] mem_waddr,
  input  logic [W-1:0] mem_data,
  output logic         mem_ready,
  input  logic         iss_valid,
  input  logic [D-1:0] iss_waddr,
  input  logic [D-1:0] raddrA,
  input  logic [D-1:0] raddrB,
  output logic         hazA,
  output logic         hazB,
  output logic         write_en,
  output logic [D-1:0] waddr,
  output logic [W-1:0] dataALU_in,
  output logic [W-1:0] dataMem_in,
  output logic         data_source
);

  localparam int NREG = 2 ** D;
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic            last_grant;
  logic [NREG-1:0] pend;
  logic            alu_hs;
  logic            mem_hs;
  logic [D-1:0]    grant_addr;

  // A side is ready when unopposed or when it lost the previous grant.
  // The two ready terms can never both admit a handshake in one cycle.
  assign alu_ready  = !mem_valid || (last_grant == GRANT_MEM);
  assign mem_ready  = !alu_valid || (last_grant == GRANT_ALU);
  assign alu_hs     = alu_valid && alu_ready;
  assign mem_hs     = mem_valid && mem_ready;
  assign grant_addr = mem_hs ? mem_waddr : alu_waddr;

  // Register 0 is never pending, so the address check only guards against
  // a stale bit; it keeps the hazard definition explicit.
  assign hazA = pend[raddrA] && (raddrA != '0);
  assign hazB = pend[raddrB] && (raddrB != '0);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      last_grant  <= GRANT_MEM;
      write_en    <= 1'b0;
      waddr       <= '0;
      dataALU_in  <= '0;
      dataMem_in  <= '0;
      data_source <= 1'b0;
    end else begin
      if (alu_hs || mem_hs) begin
        last_grant  <= mem_hs ? GRANT_MEM : GRANT_ALU;
        waddr       <= grant_addr;
        data_source <= mem_hs;
        write_en    <= (grant_addr != '0);
        if (alu_hs) dataALU_in <= alu_data;
        if (mem_hs) dataMem_in <= mem_data;
      end else begin
        write_en <= 1'b0;
      end
    end
  end

  // Issue set takes priority over writeback clear on the same register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_valid && (iss_waddr == D'(i)))
          pend[i] <= 1'b1;
        else if (write_en && (waddr == D'(i)))
          pend[i] <= 1'b0;
      end
      pend[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_wb_sched.sv
module tb_reg_file_wb_sched;
  localparam int W = 8;
  localparam int D = 4;
  localparam int NREG = 16;

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic         alu_valid = 0, mem_valid = 0, iss_valid = 0;
  logic [D-1:0] alu_waddr = 0, mem_waddr = 0, iss_waddr = 0, raddrA = 0, raddrB = 0;
  logic [W-1:0] alu_data = 0, mem_data = 0;
  logic         alu_ready, mem_ready, hazA, hazB, write_en, data_source;
  logic [D-1:0] waddr;
  logic [W-1:0] dataALU_in, dataMem_in;

  int errors = 0;
  int checks = 0;

  // Reference model: arbiter memory, pending set, and the write the register
  // file is performing this cycle.
  bit         m_mem_last;
  bit         m_pend [NREG];
  bit         m_we;
  int         m_addr;
  int         m_dalu, m_dmem;
  bit         m_src;
  bit         prev_alu_acc, prev_mem_acc;

  reg_file_wb_sched #(.W(W), .D(D)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .raddrA(raddrA), .raddrB(raddrB), .hazA(hazA), .hazB(hazB),
    .write_en(write_en), .waddr(waddr), .dataALU_in(dataALU_in),
    .dataMem_in(dataMem_in), .data_source(data_source)
  );

  always #5 CLK = ~CLK;

  function automatic bit exp_alu_ready();
    return !mem_valid || m_mem_last;
  endfunction

  function automatic bit exp_mem_ready();
    return !alu_valid || !m_mem_last;
  endfunction

  function automatic bit exp_haz(int r);
    return (r != 0) && m_pend[r];
  endfunction

  task automatic model_reset();
    m_mem_last = 1; m_we = 0; m_addr = 0; m_dalu = 0; m_dmem = 0; m_src = 0;
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    prev_alu_acc = 0; prev_mem_acc = 0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_waddr = 0; mem_waddr = 0; iss_waddr = 0;
    alu_data = 0; mem_data = 0; raddrA = 0; raddrB = 0;
  endtask

  // Advance one clock: model consumes this cycle's inputs, then the bench
  // resumes 1 time unit after the rising edge.
  task automatic tick();
    bit a_acc, b_acc;
    a_acc = alu_valid && exp_alu_ready();
    b_acc = mem_valid && exp_mem_ready();
    // Retire the write in flight, then record a newly issued destination.
    if (m_we) m_pend[m_addr] = 0;
    if (iss_valid && iss_waddr != 0) m_pend[iss_waddr] = 1;
    if (a_acc) begin
      m_mem_last = 0; m_addr = alu_waddr; m_dalu = alu_data; m_src = 0; m_we = (alu_waddr != 0);
    end else if (b_acc) begin
      m_mem_last = 1; m_addr = mem_waddr; m_dmem = mem_data; m_src = 1; m_we = (mem_waddr != 0);
    end else begin
      m_we = 0;
    end
    prev_alu_acc = a_acc; prev_mem_acc = b_acc;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST_n = 0;
    model_reset();
    @(posedge CLK);
    #1;
    RST_n = 1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    raddrA = 3; raddrB = 9;
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got=%b exp=0", write_en); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    checks++; if (dataALU_in !== 8'h00 || dataMem_in !== 8'h00) begin errors++; $display("FAIL reset_data got=%h/%h exp=00/00", dataALU_in, dataMem_in); end
    checks++; if (data_source !== 1'b0) begin errors++; $display("FAIL reset_src got=%b exp=0", data_source); end
    checks++; if (hazA !== 1'b0 || hazB !== 1'b0) begin errors++; $display("FAIL reset_haz got=%b%b exp=00", hazA, hazB); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_idle got=%b%b exp=11", alu_ready, mem_ready); end
    alu_valid = 1; mem_valid = 1;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_first_conflict got=%b%b exp=10", alu_ready, mem_ready); end
    idle_inputs();
  endtask

  task automatic test_alu_alone();
    apply_reset();
    alu_valid = 1; alu_waddr = 3; alu_data = 8'h5A;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_alone_ready got=%b exp=1", alu_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (write_en !== 1'b1 || waddr !== 4'd3) begin errors++; $display("FAIL alu_alone_write got=%b/%0d exp=1/3", write_en, waddr); end
    checks++; if (dataALU_in !== 8'h5A || data_source !== 1'b0) begin errors++; $display("FAIL alu_alone_data got=%h/%b exp=5a/0", dataALU_in, data_source); end
    tick();
    checks++; if (write_en !== 1'b0 || waddr !== 4'd3) begin errors++; $display("FAIL alu_alone_idle got=%b/%0d exp=0/3", write_en, waddr); end
  endtask

  task automatic test_conflict();
    apply_reset();
    alu_valid = 1; alu_waddr = 2; alu_data = 8'h11;
    mem_valid = 1; mem_waddr = 5; mem_data = 8'h22;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL conflict_c0_ready got=%b%b exp=10", alu_ready, mem_ready); end
    tick();
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL conflict_c1_ready got=%b%b exp=01", alu_ready, mem_ready); end
    checks++; if (write_en !== 1'b1 || waddr !== 4'd2 || dataALU_in !== 8'h11 || data_source !== 1'b0) begin errors++; $display("FAIL conflict_c1_write got=%b/%0d/%h/%b exp=1/2/11/0", write_en, waddr, dataALU_in, data_source); end
    tick();
    idle_inputs();
    #1;
    checks++; if (write_en !== 1'b1 || waddr !== 4'd5 || dataMem_in !== 8'h22 || data_source !== 1'b1) begin errors++; $display("FAIL conflict_c2_write got=%b/%0d/%h/%b exp=1/5/22/1", write_en, waddr, dataMem_in, data_source); end
    checks++; if (dataALU_in !== 8'h11) begin errors++; $display("FAIL conflict_alu_hold got=%h exp=11", dataALU_in); end
    tick();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    iss_valid = 1; iss_waddr = 7; raddrA = 7; raddrB = 6;
    tick();
    iss_valid = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) begin mem_valid = 1; mem_waddr = 7; mem_data = 8'hC3; end
      else mem_valid = 0;
      #1;
      checks++; if (hazA !== 1'b1 || hazB !== 1'b0) begin errors++; $display("FAIL sb_pending_c%0d got=%b%b exp=10", c, hazA, hazB); end
      tick();
    end
    checks++; if (hazA !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b exp=0", hazA); end
    idle_inputs();
  endtask

  task automatic test_set_beats_clear();
    apply_reset();
    iss_valid = 1; iss_waddr = 4; raddrA = 4;
    tick();
    iss_valid = 0; mem_valid = 1; mem_waddr = 4; mem_data = 8'h44;
    tick();
    mem_valid = 0; iss_valid = 1; iss_waddr = 4;
    #1;
    checks++; if (write_en !== 1'b1 || waddr !== 4'd4 || hazA !== 1'b1) begin errors++; $display("FAIL sbc_setup got=%b/%0d/%b exp=1/4/1", write_en, waddr, hazA); end
    tick();
    iss_valid = 0;
    #1;
    checks++; if (hazA !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=1", hazA); end
    idle_inputs();
  endtask

  task automatic test_reg0();
    apply_reset();
    mem_valid = 1; mem_waddr = 0; mem_data = 8'h99; iss_valid = 1; iss_waddr = 0; raddrA = 0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL r0_mem_ready got=%b exp=1", mem_ready); end
    tick();
    idle_inputs();
    alu_valid = 1; alu_waddr = 0; alu_data = 8'h77;
    #1;
    checks++; if (write_en !== 1'b0 || hazA !== 1'b0) begin errors++; $display("FAIL r0_no_write got=%b/%b exp=0/0", write_en, hazA); end
    tick();
    alu_valid = 1; mem_valid = 1; mem_waddr = 1;
    #1;
    // ALU took the last grant on register 0, so MEM must win this conflict.
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL r0_grant_update got=%b%b exp=01", alu_ready, mem_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL r0_alu_no_write got=%b exp=0", write_en); end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    iss_valid = 1; iss_waddr = 3; raddrA = 3;
    alu_valid = 1; alu_waddr = 5; alu_data = 8'hE1;
    tick();
    idle_inputs();
    raddrA = 3;
    #1;
    checks++; if (write_en !== 1'b1 || hazA !== 1'b1) begin errors++; $display("FAIL areset_setup got=%b/%b exp=1/1", write_en, hazA); end
    #1;
    RST_n = 0;
    #1;
    checks++; if (write_en !== 1'b0 || hazA !== 1'b0) begin errors++; $display("FAIL areset_immediate got=%b/%b exp=0/0", write_en, hazA); end
    checks++; if (waddr !== 4'd0 || dataALU_in !== 8'h00 || data_source !== 1'b0) begin errors++; $display("FAIL areset_outputs got=%0d/%h/%b exp=0/00/0", waddr, dataALU_in, data_source); end
    model_reset();
    @(posedge CLK);
    #1;
    RST_n = 1;
    #1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(alu_valid && !prev_alu_acc)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_waddr = D'($urandom_range(0, NREG - 1));
        alu_data  = W'($urandom);
      end
      if (!(mem_valid && !prev_mem_acc)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_waddr = D'($urandom_range(0, NREG - 1));
        mem_data  = W'($urandom);
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_waddr = D'($urandom_range(0, NREG - 1));
      raddrA    = D'($urandom_range(0, NREG - 1));
      raddrB    = D'($urandom_range(0, NREG - 1));
      #1;
      checks++; if (alu_ready !== exp_alu_ready() || mem_ready !== exp_mem_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, alu_ready, mem_ready, exp_alu_ready(), exp_mem_ready()); end
      checks++; if (write_en !== m_we || (m_we && waddr !== D'(m_addr))) begin errors++; $display("FAIL rnd_write c=%0d got=%b/%0d exp=%b/%0d", c, write_en, waddr, m_we, m_addr); end
      checks++; if (dataALU_in !== W'(m_dalu) || dataMem_in !== W'(m_dmem) || data_source !== m_src) begin errors++; $display("FAIL rnd_data c=%0d got=%h/%h/%b exp=%h/%h/%b", c, dataALU_in, dataMem_in, data_source, m_dalu, m_dmem, m_src); end
      checks++; if (hazA !== exp_haz(raddrA) || hazB !== exp_haz(raddrB)) begin errors++; $display("FAIL rnd_haz c=%0d got=%b%b exp=%b%b", c, hazA, hazB, exp_haz(raddrA), exp_haz(raddrB)); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_alone();
    test_conflict();
    test_scoreboard();
    test_set_beats_clear();
    test_reg0();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_wb_sched.md
# reg_file_wb_sched

Writeback scheduler and scoreboard for the single-write-port register file. Arbitrates between the ALU writeback and memory-load writeback requesters with round-robin fairness and drives the register file's write port (write_en, waddr, dataALU_in, dataMem_in, data_source) from registered outputs. Tracks per-register pending-write bits so decode can stall on read-after-write hazards. Sits between the execute/memory stages and the register file.

## Interface

- W, 8, data width (matches register file)
- D, 4, register address width; 2**D registers

- CLK  input  1  clock; all state changes on rising edge
- RST_n  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU writeback request
- alu_waddr  input  D  ALU destination register
- alu_data  input  W  ALU result
- alu_ready  output  1  ALU request accepted this cycle when alu_valid & alu_ready
- mem_valid  input  1  load writeback request
- mem_waddr  input  D  load destination register
- mem_data  input  W  load data
- mem_ready  output  1  load request accepted this cycle when mem_valid & mem_ready
- iss_valid  input  1  instruction issuing with a destination register
- iss_waddr  input  D  destination of issuing instruction
- raddrA, raddrB  input  D  source registers being decoded
- hazA, hazB  output  1  source register has a pending write
- write_en  output  1  register file write enable (registered)
- waddr  output  D  register file write address (registered)
- dataALU_in  output  W  ALU data to register file (registered)
- dataMem_in  output  W  memory data to register file (registered)
- data_source  output  1  1 = write dataMem_in, 0 = write dataALU_in (registered)

## Operation

- Arbitration: state bit last_grant (0 = ALU, 1 = MEM).
  - alu_ready = !mem_valid | (last_grant == MEM); mem_ready = !alu_valid | (last_grant == ALU). Combinational, defined regardless of own valid.
  - Only one side valid: that side is ready, granted at once.
  - Both valid: side opposite last_grant wins; loser's ready low, loser holds valid/addr/data stable until accepted.
  - last_grant updates to the granted side on every handshake; unchanged if no handshake.
- Write stage: on handshake, register waddr ← requester addr, data_source ← (grant == MEM), dataALU_in ← alu_data if ALU granted, dataMem_in ← mem_data if MEM granted (other data register holds), write_en ← (addr != 0). No handshake: write_en ← 0, other write outputs hold.
- Register 0: request to waddr 0 is accepted normally (handshake, last_grant update) but write_en stays 0; never marked pending.
- Scoreboard pend[2**D]:
  - Set pend[iss_waddr] when iss_valid & iss_waddr != 0.
  - Clear pend[waddr] when write_en output is 1 (same edge the register file writes).
  - Set and clear of same register same edge: set wins.
  - hazA = pend[raddrA] & (raddrA != 0); hazB likewise. Combinational from current state; no bypass of same-cycle set/clear.
- No data forwarding; consumers re-read after haz drops.

## Timing

- Reset (RST_n low, async): write_en=0, waddr=0, dataALU_in=0, dataMem_in=0, data_source=0, last_grant=MEM (ALU wins first conflict), all pend=0 so hazA=hazB=0. alu_ready/mem_ready follow combinational rules from reset state.
- Reset mid-operation: accepted-but-unwritten request is dropped; all pending bits lost.
- Latency: handshake in cycle N → write_en high in cycle N+1 → register file updated at end of N+1 → data readable and pend clear in cycle N+2.
- Throughput: one writeback per cycle; under continuous dual requests, grants alternate ALU, MEM, ALU, ...
- Issue at cycle N → hazard visible from cycle N+1.

## Test plan

- Reset then ALU alone: alu_valid=1, alu_waddr=3, alu_data=8'h5A at cycle 0 → alu_ready=1; cycle 1 write_en=1, waddr=3, dataALU_in=8'h5A, data_source=0.
- Conflict after reset: both valid (ALU→r2=8'h11, MEM→r5=8'h22) held → cycle 0 ALU granted, mem_ready=0; cycle 1 MEM granted, write_en=1 waddr=2; cycle 2 write_en=1 waddr=5 data_source=1 dataMem_in=8'h22.
- Scoreboard: iss_valid r7 at cycle 0, raddrA=7 → hazA=1 from cycle 1; MEM writeback r7 handshake cycle 4 → write_en cycle 5, hazA=0 cycle 6.
- Set beats clear: r4 pending, write_en to r4 and iss_valid r4 same cycle → hazA (raddrA=4) remains 1 next cycle.
- Register 0: mem_valid waddr=0 → mem_ready=1, next cycle write_en=0; iss_valid r0 → hazA with raddrA=0 stays 0.
- Async reset: drop RST_n mid-cycle with write_en=1 and pend[3]=1 → write_en, pend, outputs zero immediately without clock edge.
